// File: rtl/gpr_scan_reader_pkg.sv
// Shared constants and scan-state encoding for the register-file read-out engine.
package gpr_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DWELL,
        WAIT_STEP,
        DONE
    } scan_state_t;

endpackage

// File: rtl/gpr_scan_reader_if.sv
// Register-file read port plus board display path driven by the scan reader.
interface gpr_scan_reader_if #(
    parameter int unsigned DATA_W = gpr_pkg::DATA_W,
    parameter int unsigned ADDR_W = gpr_pkg::ADDR_W
);

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    modport master (
        output rd_addr,
        input  rd_data,
        output disp_addr,
        output disp_data,
        output disp_valid
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  disp_addr,
        input  disp_data,
        input  disp_valid
    );

endinterface

// File: rtl/gpr_scan_reader_rise_edge.sv
// Synchronous rising-edge detector; a level already high when reset releases
// is treated as history and does not produce a pulse.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_r;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_r   <= d;
            armed <= 1'b1;
        end
    end

    // armed masks the first post-reset cycle, when d_r still holds its reset 0
    assign pulse = d & ~d_r & armed;

endmodule

// File: rtl/gpr_scan_reader.sv
// Sequential read-out of the general-purpose register file to the display path.
// Optional XOR checksum of the scanned registers: define GPR_SCAN_CHECKSUM_EN.
module gpr_scan_reader
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W       = gpr_pkg::DATA_W,
    parameter int unsigned ADDR_W       = gpr_pkg::ADDR_W,
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  mode_auto,
    gpr_scan_reader_if.master     bus,
`ifdef GPR_SCAN_CHECKSUM_EN
    output logic [DATA_W-1:0]     csum,
    output logic                  csum_valid,
`endif
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned       CNT_W     = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL_CYCLES - 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             auto_mode;
    logic             start_p;
    logic             step_p;
    logic             advance;

    rise_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (start),
        .pulse (start_p)
    );

    rise_edge u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (step),
        .pulse (step_p)
    );

    // Auto mode ends its dwell on the terminal count; manual mode on a step edge.
    always_comb begin
        advance = 1'b0;
        if (state == DWELL && cnt == CNT_LAST) begin
            advance = 1'b1;
        end else if (state == WAIT_STEP && step_p) begin
            advance = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            auto_mode      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.disp_addr  <= '0;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef GPR_SCAN_CHECKSUM_EN
            csum           <= '0;
            csum_valid     <= 1'b0;
`endif
        end else begin
            bus.disp_valid <= 1'b0;
            if (stop) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
`ifdef GPR_SCAN_CHECKSUM_EN
                csum_valid <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_p) begin
                            state       <= CAPTURE;
                            auto_mode   <= mode_auto;
                            bus.rd_addr <= '0;
                            cnt         <= '0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
`ifdef GPR_SCAN_CHECKSUM_EN
                            csum       <= '0;
                            csum_valid <= 1'b0;
`endif
                        end
                    end
                    CAPTURE: begin
                        bus.disp_addr  <= bus.rd_addr;
                        bus.disp_data  <= bus.rd_data;
                        bus.disp_valid <= 1'b1;
`ifdef GPR_SCAN_CHECKSUM_EN
                        csum <= csum ^ bus.rd_data;
`endif
                        state <= auto_mode ? DWELL : WAIT_STEP;
                    end
                    DWELL, WAIT_STEP: begin
                        if (state == DWELL) begin
                            cnt <= advance ? '0 : cnt + 1'b1;
                        end
                        if (advance) begin
                            if (bus.rd_addr == LAST_ADDR) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
`ifdef GPR_SCAN_CHECKSUM_EN
                                csum_valid <= 1'b1;
`endif
                            end else begin
                                bus.rd_addr <= bus.rd_addr + 1'b1;
                                state       <= CAPTURE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
